// File: rtl/rv32i_pkg.sv
// Shared RV32I constants: major opcodes, funct7 values and ALU control codes.
// The control codes are the contract between the dispatch stage and the ALU;
// change them in one place only.
package rv32i_pkg;

    // Major opcodes handled by the integer dispatch stage
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // funct7 values: base encoding and the SUB/SRA alternate
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // ALU control codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SLT  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SRA  = 4'b1010;
    localparam logic [3:0] ALU_SUB  = 4'b1011;

    // Zero-extend a 5-bit shift amount to a full operand
    function automatic logic [31:0] shamt_operand(input logic [4:0] amt);
        return {27'b0, amt};
    endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC into ALU operands.
// Ports: instr/pc/rs1/rs2 in; a, b, ctrl, rd, rd_we, illegal out.
// Undecodable words produce illegal=1 with a zero operand pair and ADD control.
module alu_decode
    import rv32i_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [3:0]  ctrl,
    output logic [4:0]  rd,
    output logic        rd_we,
    output logic        illegal
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_u;

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic        legal;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign imm_u  = {instr[31:12], 12'b0};

    always_comb begin
        dec_a    = '0;
        dec_b    = '0;
        dec_ctrl = ALU_ADD;
        legal    = 1'b0;

        unique case (opcode)
            OPC_OP: begin
                dec_a = rs1;
                dec_b = rs2;
                // Only base funct7 is legal, except the alternate on ADD/SRL slots
                legal = (funct7 == F7_BASE);
                unique case (funct3)
                    3'b000: begin
                        dec_ctrl = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                        legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_b    = shamt_operand(rs2[4:0]);
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_b    = shamt_operand(rs2[4:0]);
                        legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    3'b111: dec_ctrl = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                dec_a = rs1;
                dec_b = imm_i;
                legal = 1'b1;
                unique case (funct3)
                    3'b000: dec_ctrl = ALU_ADD;
                    3'b001: begin
                        dec_ctrl = ALU_SLL;
                        dec_b    = shamt_operand(instr[24:20]);
                        legal    = (funct7 == F7_BASE);
                    end
                    3'b010: dec_ctrl = ALU_SLT;
                    3'b011: dec_ctrl = ALU_SLTU;
                    3'b100: dec_ctrl = ALU_XOR;
                    3'b101: begin
                        dec_ctrl = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                        dec_b    = shamt_operand(instr[24:20]);
                        legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    end
                    3'b110: dec_ctrl = ALU_OR;
                    3'b111: dec_ctrl = ALU_AND;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LUI: begin
                dec_a    = '0;
                dec_b    = imm_u;
                dec_ctrl = ALU_ADD;
                legal    = 1'b1;
            end
            OPC_AUIPC: begin
                dec_a    = pc;
                dec_b    = imm_u;
                dec_ctrl = ALU_ADD;
                legal    = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

    // Illegal words still travel downstream so the trap is taken in order,
    // but with a neutral payload that cannot write the register file.
    assign a       = legal ? dec_a    : '0;
    assign b       = legal ? dec_b    : '0;
    assign ctrl    = legal ? dec_ctrl : ALU_ADD;
    assign rd      = instr[11:7];
    assign rd_we   = legal && (instr[11:7] != 5'd0);
    assign illegal = !legal;

endmodule

// File: rtl/alu_dispatch.sv
// Registered decode/dispatch stage in front of the ALU, 1-cycle latency.
// Ports: in_* valid/ready instruction side, out_* valid/ready ALU side, flush, issue_count.
// Single output register: accepts when empty or draining; flush blocks accept and clears out_valid.
module alu_dispatch
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_ctrl,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_illegal,
    output logic [31:0]     issue_count
);

    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_ctrl;
    logic [4:0]  dec_rd;
    logic        dec_rd_we;
    logic        dec_illegal;

    logic        accept;
    logic        handshake;

    alu_decode u_decode (
        .instr   (in_instr),
        .pc      (in_pc),
        .rs1     (in_rs1_data),
        .rs2     (in_rs2_data),
        .a       (dec_a),
        .b       (dec_b),
        .ctrl    (dec_ctrl),
        .rd      (dec_rd),
        .rd_we   (dec_rd_we),
        .illegal (dec_illegal)
    );

    // out_ready reaches in_ready combinationally so a draining register refills
    // in the same edge; nothing else crosses from input to output.
    assign in_ready  = !flush && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign handshake = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
        end else if (flush || handshake) begin
            out_valid <= 1'b0;
        end
    end

    // Payload only moves on accept, so it is stable through any stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_a       <= '0;
            out_b       <= '0;
            out_ctrl    <= ALU_ADD;
            out_rd      <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_a       <= dec_a;
            out_b       <= dec_b;
            out_ctrl    <= dec_ctrl;
            out_rd      <= dec_rd;
            out_rd_we   <= dec_rd_we;
            out_illegal <= dec_illegal;
        end
    end

    // A handshake completing in a flush cycle still counts; wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
        end else if (handshake) begin
            issue_count <= issue_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_alu_dispatch.sv
module tb_alu_dispatch;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs1_data;
    logic [31:0] in_rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_ctrl;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic        out_illegal;
    logic [31:0] issue_count;

    int checks;
    int failures;
    logic [31:0] exp_cnt;

    alu_dispatch #(.XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_ctrl    (out_ctrl),
        .out_rd      (out_rd),
        .out_rd_we   (out_rd_we),
        .out_illegal (out_illegal),
        .issue_count (issue_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] rs1, input logic [31:0] rs2);
        in_valid    = 1'b1;
        in_instr    = instr;
        in_pc       = pc;
        in_rs1_data = rs1;
        in_rs2_data = rs2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || out_ctrl !== 4'h0 ||
            out_rd !== 5'h0 || out_rd_we !== 1'b0 || out_illegal !== 1'b0 || issue_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: valid=%b a=%h b=%h ctrl=%h rd=%h we=%b ill=%b cnt=%h, required all zero",
                     out_valid, out_a, out_b, out_ctrl, out_rd, out_rd_we, out_illegal, issue_count);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        exp_cnt = 32'h0;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h10 || out_b !== 32'hFFFFFFFF || out_ctrl !== 4'b0000 ||
            out_rd !== 5'd5 || out_rd_we !== 1'b1 || out_illegal !== 1'b0) begin
            failures++;
            $display("FAIL addi: valid=%b a=%h b=%h ctrl=%b rd=%0d we=%b ill=%b, required 1 10 ffffffff 0000 5 1 0",
                     out_valid, out_a, out_b, out_ctrl, out_rd, out_rd_we, out_illegal);
        end
        tick();
        exp_cnt = exp_cnt + 1;
        checks++;
        if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL addi_drain: valid=%b cnt=%0d, required 0 %0d", out_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        // SRA x3,x2,x4 with rs2=0x123 -> shift amount 3
        drive(32'h404151B3, 32'h0, 32'h8000_0000, 32'h0000_0123);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_a !== 32'h8000_0000 || out_b !== 32'h3 || out_ctrl !== 4'b1010 ||
            out_rd !== 5'd3 || out_rd_we !== 1'b1) begin
            failures++;
            $display("FAIL sra: valid=%b a=%h b=%h ctrl=%b rd=%0d we=%b, required 1 80000000 3 1010 3 1",
                     out_valid, out_a, out_b, out_ctrl, out_rd, out_rd_we);
        end
        // SUB x6,x7,x8
        drive(32'h40838333, 32'h0, 32'd50, 32'd7);
        tick();
        checks++;
        if (out_a !== 32'd50 || out_b !== 32'd7 || out_ctrl !== 4'b1011 || out_rd !== 5'd6 ||
            issue_count !== exp_cnt + 1) begin
            failures++;
            $display("FAIL sub: a=%h b=%h ctrl=%b rd=%0d cnt=%0d, required 32 7 1011 6 %0d",
                     out_a, out_b, out_ctrl, out_rd, issue_count, exp_cnt + 1);
        end
        // SLTIU x9,x10,5
        drive(32'h00553493, 32'h0, 32'd4, 32'h0);
        tick();
        checks++;
        if (out_a !== 32'd4 || out_b !== 32'd5 || out_ctrl !== 4'b0010 || out_rd !== 5'd9 ||
            issue_count !== exp_cnt + 2) begin
            failures++;
            $display("FAIL sltiu: a=%h b=%h ctrl=%b rd=%0d cnt=%0d, required 4 5 0010 9 %0d",
                     out_a, out_b, out_ctrl, out_rd, issue_count, exp_cnt + 2);
        end
        // LUI x1,0x12345
        drive(32'h123450B7, 32'h0, 32'hDEAD_BEEF, 32'h0);
        tick();
        checks++;
        if (out_a !== 32'h0 || out_b !== 32'h12345000 || out_ctrl !== 4'b0000 || out_rd !== 5'd1) begin
            failures++;
            $display("FAIL lui: a=%h b=%h ctrl=%b rd=%0d, required 0 12345000 0000 1",
                     out_a, out_b, out_ctrl, out_rd);
        end
        // AUIPC x2,1 at pc 0x100
        drive(32'h00001117, 32'h100, 32'h0, 32'h0);
        tick();
        checks++;
        if (out_a !== 32'h100 || out_b !== 32'h1000 || out_ctrl !== 4'b0000 || out_rd !== 5'd2) begin
            failures++;
            $display("FAIL auipc: a=%h b=%h ctrl=%b rd=%0d, required 100 1000 0000 2",
                     out_a, out_b, out_ctrl, out_rd);
        end
        in_valid = 1'b0;
        tick();
        exp_cnt = exp_cnt + 5;
        checks++;
        if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL b2b_count: valid=%b cnt=%0d, required 0 %0d", out_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        // ADD x0,x1,x2: legal but no writeback
        drive(32'h00208033, 32'h0, 32'd11, 32'd22);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_rd_we !== 1'b0 || out_illegal !== 1'b0 || out_a !== 32'd11) begin
            failures++;
            $display("FAIL add_x0: valid=%b we=%b ill=%b a=%h, required 1 0 0 b", out_valid, out_rd_we, out_illegal, out_a);
        end
        out_ready = 1'b0;
        drive(32'h123450B7, 32'h0, 32'h0, 32'h0);
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_a !== 32'd11 || out_b !== 32'd22 ||
                issue_count !== exp_cnt) begin
                failures++;
                $display("FAIL stall_%0d: in_ready=%b valid=%b a=%h b=%h cnt=%0d, required 0 1 b 16 %0d",
                         i, in_ready, out_valid, out_a, out_b, issue_count, exp_cnt);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready: got %b required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        checks++;
        if (out_valid !== 1'b1 || out_b !== 32'h12345000 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL release_swap: valid=%b b=%h cnt=%0d, required 1 12345000 %0d",
                     out_valid, out_b, issue_count, exp_cnt);
        end
        tick();
        exp_cnt = exp_cnt + 1;
        checks++;
        if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL release_drain: valid=%b cnt=%0d, required 0 %0d", out_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(32'h0000000B, 32'h40, 32'h5555_5555, 32'hAAAA_AAAA);
        tick();
        checks++;
        if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_ctrl !== 4'b0000 ||
            out_a !== 32'h0 || out_b !== 32'h0) begin
            failures++;
            $display("FAIL illegal_opcode: valid=%b ill=%b we=%b ctrl=%b a=%h b=%h, required 1 1 0 0000 0 0",
                     out_valid, out_illegal, out_rd_we, out_ctrl, out_a, out_b);
        end
        // SLLI with funct7=0100000 is not a valid shift-immediate
        drive(32'h40109093, 32'h0, 32'h7, 32'h0);
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_illegal !== 1'b1 || out_rd_we !== 1'b0 || out_rd !== 5'd1 || out_b !== 32'h0) begin
            failures++;
            $display("FAIL illegal_slli: ill=%b we=%b rd=%0d b=%h, required 1 0 1 0",
                     out_illegal, out_rd_we, out_rd, out_b);
        end
        tick();
        exp_cnt = exp_cnt + 2;
        checks++;
        if (issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL illegal_count: cnt=%0d required %0d", issue_count, exp_cnt);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(32'hFFF08293, 32'h0, 32'h1, 32'h0);
        tick();
        flush = 1'b1;
        drive(32'h40838333, 32'h0, 32'h9, 32'h9);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL flush_cycle: in_ready=%b valid=%b, required 0 1", in_ready, out_valid);
        end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL flush_stalled: valid=%b cnt=%0d, required 0 %0d", out_valid, issue_count, exp_cnt);
        end
        // Flush coinciding with a completing handshake still counts it
        out_ready = 1'b1;
        drive(32'hFFF08293, 32'h0, 32'h1, 32'h0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 1;
        checks++;
        if (out_valid !== 1'b0 || issue_count !== exp_cnt) begin
            failures++;
            $display("FAIL flush_handshake: valid=%b cnt=%0d, required 0 %0d", out_valid, issue_count, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        force dut.issue_count = 32'hFFFF_FFFF;
        #1;
        release dut.issue_count;
        #1;
        checks++;
        if (issue_count !== 32'hFFFF_FFFF) begin
            failures++;
            $display("FAIL wrap_preload: cnt=%h required ffffffff", issue_count);
        end
        out_ready = 1'b1;
        drive(32'h00001117, 32'h0, 32'h0, 32'h0);
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if (issue_count !== 32'h0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap: cnt=%h valid=%b, required 0 0", issue_count, out_valid);
        end
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b0;
        drive(32'hFFF08293, 32'h0, 32'h10, 32'h0);
        tick();
        tick();
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_reset_stall: valid=%b in_ready=%b, required 1 0", out_valid, in_ready);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_a !== 32'h0 || out_b !== 32'h0 || out_ctrl !== 4'h0 ||
            out_rd !== 5'h0 || out_rd_we !== 1'b0 || out_illegal !== 1'b0 || issue_count !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_stall: valid=%b a=%h b=%h ctrl=%h rd=%h we=%b ill=%b cnt=%h, required all zero",
                     out_valid, out_a, out_b, out_ctrl, out_rd, out_rd_we, out_illegal, issue_count);
        end
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: in_ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        exp_cnt     = 32'h0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = 32'h0;
        in_pc       = 32'h0;
        in_rs1_data = 32'h0;
        in_rs2_data = 32'h0;
        flush       = 1'b0;
        out_ready   = 1'b1;

        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_flush();
        test_wrap();
        test_reset_mid_stall();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
